seq_array_multiplier: RTL and testbench
=======================================

Name: seq_array_multiplier

Overview:
- Parametrised iterative shift-add multiplier. Generational successor to the fixed 4x4 combinational array multiplier.
- Supports WIDTH-bit operands, unsigned or two's-complement mode per transaction, and valid/ready handshakes on input and output.
- Processes one partial product per clock, trading latency for area.
- Used where a full combinational array is too large or too deep for timing.

Parameters:
WIDTH, 8, operand width in bits (minimum 2); product is 2*WIDTH bits.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
in_valid  input  1  operands and mode valid
in_ready  output  1  block can accept operands; high only in IDLE
a  input  WIDTH  multiplicand
b  input  WIDTH  multiplier
signed_mode  input  1  1 = a, b and product are two's complement; 0 = unsigned
out_valid  output  1  product valid
out_ready  input  1  consumer accepts product
product  output  2*WIDTH  result of a*b
busy  output  1  high in CALC or DONE

Behaviour:
- Reset (rst_n low at a clk edge):
  - state -> IDLE.
  - out_valid=0, product=0, busy=0.
  - in_ready forced 0 while rst_n is low.
  - Internal accumulator, counter, operand and sign registers cleared.
  - Reset mid-CALC or mid-DONE aborts the operation; the result is discarded and never presented.
- States:
  - IDLE: in_ready=1.
    - in_valid & in_ready at edge E0: capture operands.
    - signed_mode=1: store |a|, |b| as WIDTH-bit unsigned magnitudes; neg_flag = a[WIDTH-1]^b[WIDTH-1].
    - signed_mode=0: store a, b unchanged; neg_flag = 0.
    - Then clear accumulator, set count=0, go to CALC.
  - CALC: each edge processes one multiplier bit.
    - If the current multiplier LSB is 1, add the multiplicand, aligned to the bit weight, into the 2*WIDTH-bit accumulator.
    - Shift the multiplier right; count increments.
    - At the WIDTH-th CALC edge (E0+WIDTH), load product = neg_flag ? two's-complement negation of the final accumulator : final accumulator. Set out_valid=1 and go to DONE.
    - in_valid is ignored during CALC.
  - DONE: out_valid=1; product and out_valid held stable while out_ready=0.
    - out_valid & out_ready at an edge: out_valid -> 0, go to IDLE.
    - product keeps its last value (not cleared).
- Latency and throughput:
  - out_valid rises in the cycle after edge E0+WIDTH, i.e. WIDTH cycles after the accept edge.
  - No same-cycle accept on output handshake; in_ready rises the cycle after the product is consumed.
  - Minimum initiation interval: WIDTH+2 cycles.
- Arithmetic: all additions are 2*WIDTH bits wide; no overflow is possible.
  - Signed corner case: -2^(WIDTH-1) has magnitude 2^(WIDTH-1), which fits in a WIDTH-bit unsigned value.
  - (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2) is representable as a positive 2*WIDTH-bit signed value.
  - Zero result with neg_flag=1 must yield 0, not a negative encoding.
- Operand inputs a, b and signed_mode are sampled only at the accept edge; later changes have no effect.
- busy = (state != IDLE).

Test Plan:
- WIDTH=8, unsigned, a=13, b=11 -> out_valid exactly 8 cycles after accept, product=0x008F; in_ready=0 throughout.
- WIDTH=8, unsigned, a=255, b=255 -> product=0xFE01.
- WIDTH=8, unsigned, a=0, b=200 -> product=0x0000.
- WIDTH=8, signed:
  - a=0xFD (-3), b=0x05 -> product=0xFFF1 (-15).
  - a=0x80, b=0x80 -> product=0x4000.
  - a=0x80, b=0x01 -> product=0xFF80.
  - a=0x00, b=0x80 -> product=0x0000.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, toggling a/b/in_valid meanwhile -> product stable, in_ready=0, no new accept. Raise out_ready -> out_valid falls next edge; in_ready=1 the following cycle.
- Reset mid-CALC: assert rst_n=0 for one edge at count=3 -> out_valid=0, product=0, busy=0. Next transaction a=7, b=6 -> product=0x002A with normal latency.
- Back-to-back: in_valid held high with out_ready=1 for 3 transactions (unsigned 2*3, signed -1*-1, unsigned 128*2) -> products 0x0006, 0x0001, 0x0100, each spaced 10 cycles apart.

Source files
------------

// File: rtl/seq_array_multiplier.sv
// Iterative shift-add multiplier, one partial product per clock.
// Ports: clk, rst_n (sync, active low), in_valid/in_ready + a, b,
//   signed_mode; out_valid/out_ready + product; busy.
module seq_array_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_sum;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [CW-1:0]      count;
    logic               neg;
    logic               last;

    // -2^(WIDTH-1) negates to itself, which read unsigned is its magnitude.
    assign a_mag = (signed_mode && a[WIDTH-1]) ? -a : a;
    assign b_mag = (signed_mode && b[WIDTH-1]) ? -b : b;

    // mcand is shifted left each step so it is already bit-weight aligned.
    assign acc_sum = acc + (mplier[0] ? mcand : '0);
    assign last    = (count == CW'(WIDTH - 1));

    assign in_ready = rst_n && (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (in_valid) state_nxt = CALC;
            CALC: if (last) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            count     <= '0;
            neg       <= 1'b0;
            product   <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= {{WIDTH{1'b0}}, a_mag};
                        mplier <= b_mag;
                        neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                CALC: begin
                    acc    <= acc_sum;
                    mplier <= mplier >> 1;
                    mcand  <= mcand << 1;
                    count  <= count + CW'(1);
                    if (last) begin
                        // Negating zero gives zero, so no special case.
                        product   <= neg ? -acc_sum : acc_sum;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_array_multiplier.sv
// Testbench for seq_array_multiplier (WIDTH=8).
// Table vectors plus handshake, reset and back-to-back sequences.
module tb_seq_array_multiplier;

    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a_i;
    logic [W-1:0]   b_i;
    logic           s_i;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] product;
    logic           busy;

    seq_array_multiplier #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a_i),
        .b          (b_i),
        .signed_mode(s_i),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .product    (product),
        .busy       (busy)
    );

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           s;
        logic [2*W-1:0] p;
    } vec_t;

    typedef struct {
        logic [2*W-1:0] p;
        int             edge_n;
    } exp_t;

    exp_t expq[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic prev_ov = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic s);
        logic [2*W-1:0] ea;
        logic [2*W-1:0] eb;
        ea = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
        eb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
        return ea * eb;
    endfunction

    // Output side: latency on out_valid rise, value on handshake.
    always @(negedge clk) begin
        check("in_ready_vs_busy", {31'd0, in_ready},
              {31'd0, rst_n && !busy});
        if (out_valid && !prev_ov) begin
            if (expq.size() == 0) begin
                check("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                check("latency", cyc - expq[0].edge_n, 32'd8);
            end
        end
        if (out_valid && out_ready && expq.size() != 0) begin
            check("product", {16'd0, product}, {16'd0, expq[0].p});
            void'(expq.pop_front());
        end
        prev_ov = out_valid;
    end

    // Drive one operand set and wait for the accept edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [2*W-1:0] p,
                        input bit keep, output int acc_e);
        exp_t e;
        int n;
        a_i = a;
        b_i = b;
        s_i = s;
        in_valid = 1'b1;
        acc_e = -1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 100) begin
                check("accept_timeout", 32'd1, 32'd0);
                in_valid = 1'b0;
                return;
            end
        end
        acc_e = cyc + 1;
        e.p = p;
        e.edge_n = acc_e;
        expq.push_back(e);
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && expq.size() != 0; i++) @(posedge clk);
        #1;
        check("drain", expq.size(), 32'd0);
    endtask

    vec_t tbl[7];
    int   e1, e2, e3, n;
    logic [W-1:0] ra, rb;
    logic rs;

    initial begin
        tbl[0] = '{8'd13,  8'd11,  1'b0, 16'h008F};
        tbl[1] = '{8'd255, 8'd255, 1'b0, 16'hFE01};
        tbl[2] = '{8'd0,   8'd200, 1'b0, 16'h0000};
        tbl[3] = '{8'hFD,  8'h05,  1'b1, 16'hFFF1};
        tbl[4] = '{8'h80,  8'h80,  1'b1, 16'h4000};
        tbl[5] = '{8'h80,  8'h01,  1'b1, 16'hFF80};
        tbl[6] = '{8'h00,  8'h80,  1'b1, 16'h0000};

        rst_n = 1'b0;
        in_valid = 1'b0;
        a_i = '0;
        b_i = '0;
        s_i = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_product", {16'd0, product}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].p, 1'b0, e1);
            drain();
        end

        for (int i = 0; i < 6; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            send(ra, rb, rs, model(ra, rb, rs), 1'b0, e1);
            drain();
        end

        // Backpressure: result held while consumer stalls.
        out_ready = 1'b0;
        send(8'd13, 8'd11, 1'b0, 16'h008F, 1'b0, e1);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bp_out_valid_seen", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            a_i = W'($urandom);
            b_i = W'($urandom);
            in_valid = ~in_valid;
            check("bp_product_hold", {16'd0, product}, 32'h008F);
            check("bp_out_valid_hold", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
            check("bp_no_accept", expq.size(), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_out_valid_fall", {31'd0, out_valid}, 32'd0);
        check("bp_in_ready_rise", {31'd0, in_ready}, 32'd1);
        check("bp_consumed", expq.size(), 32'd0);

        // Reset during CALC discards the operation.
        send(8'd9, 8'd9, 1'b0, 16'd81, 1'b0, e1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_product", {16'd0, product}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        expq.delete();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("midrst_no_result", {31'd0, out_valid}, 32'd0);
        end
        send(8'd7, 8'd6, 1'b0, 16'h002A, 1'b0, e1);
        drain();

        // Back-to-back with in_valid held high.
        send(8'd2, 8'd3, 1'b0, 16'h0006, 1'b1, e1);
        send(8'hFF, 8'hFF, 1'b1, 16'h0001, 1'b1, e2);
        send(8'd128, 8'd2, 1'b0, 16'h0100, 1'b0, e3);
        drain();
        check("b2b_gap1", e2 - e1, 32'd10);
        check("b2b_gap2", e3 - e2, 32'd10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
